key_debounce_ext: RTL and testbench



---
 rtl/key_debounce_ext_if.sv | 40 ++++
 rtl/key_debounce_ext.sv | 199 +++++++++++++++++++
 tb/tb_key_debounce_ext.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_ext_if.sv
// rtl/key_debounce_ext_if.sv - key bundle between raw key pins and debounced event outputs
//
// Purpose: groups the raw active-low key inputs with the debounced level and
//          the four per-channel event pulses.
// Signals (all N bits wide, one bit per channel):
//   key_n       raw keys, active low, asynchronous to clk
//   key_level   debounced level, 1 = pressed
//   key_pulse   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   key_long    one-cycle pulse after LONG_TICKS ticks held
//   key_repeat  one-cycle pulse every REP_TICKS ticks after key_long
// Modports: master drives key_n and observes events; slave is the debouncer.
interface key_debounce_ext_if #(
  parameter int N = 4
);
  logic [N-1:0] key_n;
  logic [N-1:0] key_level;
  logic [N-1:0] key_pulse;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic [N-1:0] key_repeat;

  modport master (
    output key_n,
    input  key_level,
    input  key_pulse,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_pulse,
    output key_release,
    output key_long,
    output key_repeat
  );
endinterface

// File: rtl/key_debounce_ext.sv
// rtl/key_debounce_ext.sv - multi-channel key debouncer with press/release/long/repeat events
//
// Purpose: per channel, synchronise an active-low raw key, accept a change only
//          after CNT_NUM consecutive cycles, present the clean level and emit
//          one-cycle press, release, long-press and auto-repeat pulses. Hold
//          timing uses one shared free-running coarse tick.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   keys   key_debounce_ext_if.slave (key_n in; key_level, key_pulse,
//          key_release, key_long, key_repeat out; all N bits, registered)
module key_debounce_ext #(
  parameter int N          = 4,
  parameter int CNT_NUM    = 240000,
  parameter int WIDTH      = 18,
  parameter int TICK_NUM   = 120000,
  parameter int LONG_TICKS = 100,
  parameter int REP_TICKS  = 20,
  parameter int HW         = 8,
  parameter int REPEAT_EN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  key_debounce_ext_if.slave keys
);

  localparam int TW = (TICK_NUM > 1) ? $clog2(TICK_NUM) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_NUM - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(CNT_NUM - 1);
  localparam logic [HW-1:0]    LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0]    LONG_END  = HW'(LONG_TICKS);
  localparam logic [HW-1:0]    REP_LAST  = HW'(REP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  // Two-flop synchroniser per channel
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  // Debounce state
  logic [N-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [N-1:0]            stable_n_q, stable_n_d;

  // Shared coarse tick
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  // Hold-timer FSM per channel
  state_e               state_q [N];
  state_e               state_d [N];
  logic [N-1:0][HW-1:0] hold_q, hold_d;
  logic [N-1:0][HW-1:0] rep_q, rep_d;

  // Registered outputs
  logic [N-1:0] level_q, level_d;
  logic [N-1:0] pulse_q, pulse_d;
  logic [N-1:0] release_q, release_d;
  logic [N-1:0] long_q, long_d;
  logic [N-1:0] repeat_q, repeat_d;

  // Acceptance strobes, valid in the cycle stable_n is about to change
  logic [N-1:0] press_acc;
  logic [N-1:0] rel_acc;

  always_comb begin
    sync1_d    = keys.key_n;
    sync2_d    = sync1_q;

    // Free-running; never restarted by key activity, hence the tick-phase
    // uncertainty on the first hold tick.
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    cnt_d      = '0;
    stable_n_d = stable_n_q;
    press_acc  = '0;
    rel_acc    = '0;
    level_d    = '0;
    pulse_d    = '0;
    release_d  = '0;
    long_d     = '0;
    repeat_d   = '0;
    hold_d     = hold_q;
    rep_d      = rep_q;

    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];

      // Any single cycle of agreement leaves cnt_d at 0, restarting the count.
      if (sync2_q[i] != stable_n_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_n_d[i] = sync2_q[i];
          press_acc[i]  = ~sync2_q[i];
          rel_acc[i]    = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // Level and edge pulses are registered from the next stable value so
      // they all appear on the same edge as the stable_n update.
      level_d[i]   = ~stable_n_d[i];
      pulse_d[i]   = press_acc[i];
      release_d[i] = rel_acc[i];

      // Release takes priority over a coincident tick: no long/repeat then.
      if (rel_acc[i]) begin
        state_d[i] = ST_IDLE;
        hold_d[i]  = '0;
        rep_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            hold_d[i] = '0;
            rep_d[i]  = '0;
            if (press_acc[i]) begin
              state_d[i] = ST_HELD;
            end
          end
          ST_HELD: begin
            if (tick) begin
              if (hold_q[i] == LONG_LAST) begin
                // hold parks at LONG_TICKS; it is not advanced in LONG
                hold_d[i]  = LONG_END;
                rep_d[i]   = '0;
                long_d[i]  = 1'b1;
                state_d[i] = ST_LONG;
              end else begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end
          end
          ST_LONG: begin
            if (tick) begin
              if (rep_q[i] == REP_LAST) begin
                rep_d[i]    = '0;
                repeat_d[i] = (REPEAT_EN != 0);
              end else begin
                rep_d[i] = rep_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
            rep_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      cnt_q      <= '0;
      stable_n_q <= '1;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      rep_q      <= '0;
      level_q    <= '0;
      pulse_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      repeat_q   <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      stable_n_q <= stable_n_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign keys.key_level   = level_q;
  assign keys.key_pulse   = pulse_q;
  assign keys.key_release = release_q;
  assign keys.key_long    = long_q;
  assign keys.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce_ext.sv
// tb/tb_key_debounce_ext.sv - scoreboard bench for key_debounce_ext (repeat on and off)
module tb_key_debounce_ext;

  localparam int N = 4;

  localparam int K_PULSE   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_ev = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  key_debounce_ext_if #(.N(N)) bus0 ();
  key_debounce_ext_if #(.N(N)) bus1 ();

  key_debounce_ext #(
    .N(N), .CNT_NUM(16), .WIDTH(5), .TICK_NUM(10), .LONG_TICKS(5),
    .REP_TICKS(3), .HW(4), .REPEAT_EN(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .keys(bus0)
  );

  key_debounce_ext #(
    .N(N), .CNT_NUM(16), .WIDTH(5), .TICK_NUM(10), .LONG_TICKS(5),
    .REP_TICKS(3), .HW(4), .REPEAT_EN(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .keys(bus1)
  );

  // Expected event: kind, channel bits, key_level at that cycle, and the
  // allowed cycle window (absolute, or relative to the previous event).
  typedef struct {
    int        kind;
    logic [3:0] val;
    logic [3:0] lvl;
    bit        rel;
    int        lo;
    int        hi;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] val, input logic [3:0] lvl,
                      input bit rel, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.val = val; e.lvl = lvl; e.rel = rel; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    bus0.key_n = v;
    bus1.key_n = v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      adv(1);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d events pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every event pulse from dut0 pops one expectation; dut1 is checked
  // against the same expectation, with key_repeat required to stay 0.
  always @(negedge clk) begin
    logic [3:0] a0 [4];
    logic [3:0] a1 [4];
    exp_t e;
    int lo, hi;
    a0[0] = bus0.key_pulse; a0[1] = bus0.key_release; a0[2] = bus0.key_long; a0[3] = bus0.key_repeat;
    a1[0] = bus1.key_pulse; a1[1] = bus1.key_release; a1[2] = bus1.key_long; a1[3] = bus1.key_repeat;
    for (int k = 0; k < 4; k++) begin
      if (a0[k] != 4'b0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: kind %0d got %b expected none (cycle %0d)", k, a0[k], cyc);
        end else begin
          e  = sb.pop_front();
          lo = e.rel ? last_ev + e.lo : e.lo;
          hi = e.rel ? last_ev + e.hi : e.hi;
          chk("event_kind", k, e.kind);
          chk("event_bits", a0[k], e.val);
          chk("event_level", bus0.key_level, e.lvl);
          tests++;
          if (cyc < lo || cyc > hi) begin
            fails++;
            $display("FAIL event_time: kind %0d at cycle %0d expected %0d..%0d", k, cyc, lo, hi);
          end
          chk("norep_level", bus1.key_level, e.lvl);
          chk("norep_event", a1[k], (k == K_REPEAT) ? 4'b0 : e.val);
          last_ev = cyc;
        end
      end else if (a1[k] != 4'b0) begin
        tests++;
        fails++;
        $display("FAIL norep_spurious: kind %0d got %b expected 0 (cycle %0d)", k, a1[k], cyc);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;
    drive(4'b1111);
    rst_n = 1'b0;
    adv(3);
    chk("reset_dut0", {bus0.key_level, bus0.key_pulse, bus0.key_release, bus0.key_long, bus0.key_repeat}, 0);
    chk("reset_dut1", {bus1.key_level, bus1.key_pulse, bus1.key_release, bus1.key_long, bus1.key_repeat}, 0);
    rst_n = 1'b1;
    adv(20);

    // Clean press/release on key 0, released before any long press
    c = cyc;
    drive(4'b1110);
    push(K_PULSE, 4'b0001, 4'b0001, 0, c + 18, c + 18);
    adv(30);
    c = cyc;
    drive(4'b1111);
    push(K_RELEASE, 4'b0001, 4'b0000, 0, c + 18, c + 18);
    drain(100);
    adv(80);

    // Glitch on key 1: 10 cycles low is too short
    drive(4'b1101);
    adv(10);
    drive(4'b1111);
    adv(40);
    chk("glitch_level", bus0.key_level, 4'b0000);

    // Bounce on key 2, then steady low
    for (int i = 0; i < 12; i++) begin
      drive((i % 2 == 0) ? 4'b1011 : 4'b1111);
      adv(5);
    end
    c = cyc;
    drive(4'b1011);
    push(K_PULSE, 4'b0100, 4'b0100, 0, c + 18, c + 18);
    adv(40);
    c = cyc;
    drive(4'b1111);
    push(K_RELEASE, 4'b0100, 4'b0000, 0, c + 18, c + 18);
    drain(100);
    adv(20);

    // Long hold with repeat on key 3 (190 cycles: exactly four repeats fit)
    c = cyc;
    drive(4'b0111);
    push(K_PULSE,  4'b1000, 4'b1000, 0, c + 18, c + 18);
    push(K_LONG,   4'b1000, 4'b1000, 1, 41, 50);
    for (int i = 0; i < 4; i++) push(K_REPEAT, 4'b1000, 4'b1000, 1, 30, 30);
    adv(190);
    drive(4'b1111);
    push(K_RELEASE, 4'b1000, 4'b0000, 0, c + 208, c + 208);
    drain(100);
    adv(60);

    // Simultaneous press/release on keys 1 and 2
    c = cyc;
    drive(4'b1001);
    push(K_PULSE, 4'b0110, 4'b0110, 0, c + 18, c + 18);
    adv(30);
    c = cyc;
    drive(4'b1111);
    push(K_RELEASE, 4'b0110, 4'b0000, 0, c + 18, c + 18);
    drain(100);
    adv(20);

    // Reset while key 0 is in the long-press state
    c = cyc;
    drive(4'b1110);
    push(K_PULSE, 4'b0001, 4'b0001, 0, c + 18, c + 18);
    push(K_LONG,  4'b0001, 4'b0001, 1, 41, 50);
    adv(75);
    drain(5);
    chk("prereset_level", bus0.key_level, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("midreset_dut0", {bus0.key_level, bus0.key_pulse, bus0.key_release, bus0.key_long, bus0.key_repeat}, 0);
    adv(4);
    chk("midreset_dut1", {bus1.key_level, bus1.key_pulse, bus1.key_release, bus1.key_long, bus1.key_repeat}, 0);
    r = cyc;
    rst_n = 1'b1;
    push(K_PULSE, 4'b0001, 4'b0001, 0, r + 18, r + 18);
    push(K_LONG,  4'b0001, 4'b0001, 1, 41, 50);
    adv(62);
    c = cyc;
    drive(4'b1111);
    push(K_RELEASE, 4'b0001, 4'b0000, 0, c + 18, c + 18);
    drain(100);
    adv(50);

    chk("scoreboard_empty", sb.size(), 0);
    chk("final_level", bus0.key_level, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
